fetch_prefetch_queue: RTL and testbench



---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_prefetch_queue_fifo.sv | 58 +++++
 rtl/fetch_prefetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types: machine word width, fetch buffer entry and reset PC.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_RESET = '0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush; head is the registered
// read word, so the consumer sees no combinational path from the push side.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns fetch PC, issues imem reads, buffers {pc, instr}.
// Optional PREFETCH_BYPASS_EN forwards a response straight to the output when the buffer is empty.
module fetch_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = cpu_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0]    tag_q, tag_d;
  logic                 inflight_q, inflight_d;

  cpu_pkg::fetch_entry_t fifo_in, fifo_head;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_push, fifo_pop;
  logic                 bypass_hit, accept;
  int                   occupancy, room;

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = inflight_q && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (bypass_hit) begin
      if (!redirect) begin
        out_valid = 1'b1;
        out_pc    = tag_q;
        out_instr = imem_data;
      end
    end else if (!fifo_empty) begin
      out_valid = 1'b1;
      out_pc    = fifo_head.pc;
      out_instr = fifo_head.instr;
    end
  end

  assign accept   = out_valid && out_ready;
  assign fifo_pop = out_ready && !fifo_empty;
  // A bypassed word taken by IF/ID this cycle never occupies the buffer.
  assign fifo_push = inflight_q && !redirect && !(bypass_hit && out_ready);
  assign fifo_in   = '{pc: tag_q, instr: imem_data};

  // Space accounting includes the in-flight word and credits a pop this cycle.
  assign occupancy = int'(fifo_count) + int'(inflight_q);
  assign room      = DEPTH + int'(accept);

  assign imem_req  = !rst && !redirect && (occupancy < room);
  assign imem_addr = imem_req ? fetch_pc_q : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + WORD_W'(1);
      tag_d      = fetch_pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= cpu_pkg::PC_RESET;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .flush_i     (redirect),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  a_full_no_inflight: assert property (@(posedge clk) disable iff (rst) !(fifo_full && inflight_q));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios then random redirect/stall traffic,
// with a stream scoreboard of expected accepted PCs (instr = pc + 0x100).
module tb_fetch_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int idle = 0;

  fetch_prefetch_queue #(.DEPTH(4), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Synchronous instruction memory: data = addr + 0x100 one cycle after a request, junk otherwise.
  initial begin
    logic        r;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #3;
      r = imem_req;
      a = imem_addr;
      @(posedge clk);
      #1;
      imem_data = r ? a + 32'h100 : $urandom;
    end
  end

  // Monitor / scoreboard: expected PC stream restarts at 0 on reset and at redirect_pc on redirect.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(32'h0);
        idle = 0;
      end else begin
        if (!out_valid) begin
          chk("idle_pc_zero", out_pc, 32'h0);
          chk("idle_instr_zero", out_instr, 32'h0);
        end
        if (redirect) chk("no_req_on_redirect", {31'b0, imem_req}, 32'h0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=%h required=none", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", out_pc, e);
            chk("sb_instr", out_instr, e + 32'h100);
            exp_q.push_back(e + 32'h1);
          end
        end
        if (redirect) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc);
        end
        if (out_valid || redirect) idle = 0;
        else idle++;
        if (idle == 5) begin
          checks++;
          errors++;
          $display("FAIL liveness actual=no_valid_for_5 required=valid");
        end
      end
    end
  end

  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
  endtask

  task automatic reset_dut(input logic rdy);
    rst      = 1'b1;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    out_ready = rdy;
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] exp_pc, input string name);
    bit seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (out_valid) begin
        seen = 1;
        chk(name, out_pc, exp_pc);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=valid", name);
    end
  endtask

  initial begin
    int reqs;

    // Reset values and first-fetch latency
    @(negedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    reset_dut(1'b1);
    chk("c0_req", {31'b0, imem_req}, 32'h1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", {31'b0, out_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("c1_valid", {31'b0, out_valid}, {31'b0, BYP});
    step(1'b0, 32'h0, 1'b1);
    chk("c2_valid", {31'b0, out_valid}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("stream_valid", {31'b0, out_valid}, 32'h1);
    end

    // Stall: exactly DEPTH requests, then issue resumes with the first pop
    reset_dut(1'b0);
    reqs = int'(imem_req);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0);
      reqs += int'(imem_req);
    end
    chk("stall_reqs", reqs, 32'd4);
    chk("stall_req_low", {31'b0, imem_req}, 32'h0);
    chk("stall_head", out_pc, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("resume_req", {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h4);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("drain_valid", {31'b0, out_valid}, 32'h1);
      chk("drain_pc", out_pc, i);
    end

    // Redirect with 3 buffered and one in flight
    reset_dut(1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b0);
    chk("redir_no_req", {31'b0, imem_req}, 32'h0);
    wait_valid(32'h40, "redir_pc");
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: last wins
    step(1'b1, 32'h40, 1'b1);
    step(1'b1, 32'h80, 1'b1);
    wait_valid(32'h80, "b2b_pc");
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // PC wrap
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    wait_valid(32'hFFFF_FFFF, "wrap_top");
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_valid", {31'b0, out_valid}, 32'h1);
    chk("wrap_zero", out_pc, 32'h0);

    // Reset mid-stream with the FIFO full
    repeat (8) step(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_pc", out_pc, 32'h0);
    chk("midrst_instr", out_instr, 32'h0);
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", {31'b0, imem_req}, 32'h1);
    wait_valid(32'h0, "restart_pc");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      step(rd, rpc, ($urandom_range(0, 2) != 0));
    end
    step(1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
